// File: rtl/opb_s2p_pkg.sv
// Shared definitions for the Simulink-to-PowerPC OPB register: word map,
// control bit positions, bus FSM states and OPB bit-order helpers.
package opb_s2p_pkg;

   localparam logic [1:0] WORD_DATA = 2'd0;
   localparam logic [1:0] WORD_CTRL = 2'd1;
   localparam logic [1:0] WORD_TS   = 2'd2;

   localparam int FREEZE = 0;
   localparam int CLEAR  = 1;
   localparam int OVF    = 2;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ACK  = 1'b1
   } bus_state_e;

   // OPB numbers bit 0 as the MSB; value bit 31 travels on bus bit 0.
   function automatic logic [31:0] bus_to_val(input logic [0:31] b);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < 32; i++) begin
         v[31-i] = b[i];
      end
      return v;
   endfunction

   function automatic logic [0:31] val_to_bus(input logic [31:0] v);
      logic [0:31] b;
      b = '0;
      for (int i = 0; i < 32; i++) begin
         b[i] = v[31-i];
      end
      return b;
   endfunction

endpackage

// File: rtl/opb_s2p_bus_if.sv
// OPB slave front end: address decode, IDLE/ACK handshake FSM, registered
// read mux and latching of the control-word write for the register file.
module opb_s2p_bus_if
   import opb_s2p_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR = 32'h01008400,
   parameter logic [31:0] C_HIGHADDR = 32'h010084FF
)(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [0:31] abus_i,
   input  logic [0:3]  be_i,
   input  logic [0:31] dbus_i,
   input  logic        rnw_i,
   input  logic        select_i,
   input  logic [31:0] data_word_i,
   input  logic [31:0] ctrl_word_i,
   input  logic [31:0] ts_word_i,
   output logic [0:31] sl_dbus_o,
   output logic        xfer_ack_o,
   output logic        ctrl_wr_o,
   output logic [31:0] ctrl_wdata_o,
   output bus_state_e  state_o
);

   // Handshake: a transfer is accepted when select is high and the address
   // falls in the window; xfer_ack_o is high for exactly the one ACK cycle,
   // and read data is valid on the bus only while xfer_ack_o is high.
   bus_state_e  state_q, state_d;
   logic        hit;
   logic [1:0]  word_idx;
   logic [31:0] rd_mux;
   logic [31:0] rd_val_q;
   logic        wr_sel_d, wr_sel_q;
   logic [31:0] wdata_q;
   logic        accept;
   logic        unused_be;

   assign word_idx  = abus_i[28:29];
   assign hit       = select_i && (abus_i >= C_BASEADDR) && (abus_i <= C_HIGHADDR);
   assign unused_be = ^be_i[0:2];

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (hit && !xfer_ack_o) state_d = S_ACK;
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign accept = (state_q == S_IDLE) && (state_d == S_ACK);

   always_comb begin
      rd_mux = '0;
      case (word_idx)
         WORD_DATA: rd_mux = data_word_i;
         WORD_CTRL: rd_mux = ctrl_word_i;
         WORD_TS:   rd_mux = ts_word_i;
         default:   rd_mux = '0;
      endcase
   end

   assign wr_sel_d = !rnw_i && (word_idx == WORD_CTRL) && be_i[3];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         rd_val_q <= '0;
         wr_sel_q <= 1'b0;
         wdata_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            rd_val_q <= rnw_i ? rd_mux : 32'd0;
            wr_sel_q <= wr_sel_d;
            wdata_q  <= bus_to_val(dbus_i);
         end
      end
   end

   // Reset masks the ACK cycle immediately so a transfer cut by reset is
   // never acknowledged; the master has to re-issue it.
   assign xfer_ack_o   = (state_q == S_ACK) && !rst_i;
   assign sl_dbus_o    = xfer_ack_o ? val_to_bus(rd_val_q) : '0;
   assign ctrl_wr_o    = xfer_ack_o && wr_sel_q;
   assign ctrl_wdata_o = wdata_q;
   assign state_o      = state_q;

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// User-to-software OPB register: shadow word, update counter, sticky overflow,
// freeze control. Optional cycle timestamp with OPB_SIMULINK2PPC_TS_EN.
module opb_register_simulink2ppc
   import opb_s2p_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR   = 32'h01008400,
   parameter logic [31:0] C_HIGHADDR   = 32'h010084FF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter              C_FAMILY     = "virtex6"
)(
   input  logic        OPB_Clk,
   input  logic        OPB_Rst,
   output logic [0:31] Sl_DBus,
   output logic        Sl_errAck,
   output logic        Sl_retry,
   output logic        Sl_toutSup,
   output logic        Sl_xferAck,
   input  logic [0:31] OPB_ABus,
   input  logic [0:3]  OPB_BE,
   input  logic [0:31] OPB_DBus,
   input  logic        OPB_RNW,
   input  logic        OPB_select,
   input  logic        OPB_seqAddr,
   input  logic [31:0] user_data_in,
   input  logic        user_valid
);

   logic [31:0] shadow_q, shadow_d;
   logic [15:0] cnt_q, cnt_d;
   logic        ovf_q, ovf_d;
   logic        freeze_q, freeze_d;
   logic        ctrl_wr;
   logic [31:0] ctrl_wdata;
   logic [31:0] ctrl_word;
   logic [31:0] ts_word;
   logic        frozen_eff;
   logic        upd_accept;
   bus_state_e  bus_state;
   logic        unused_ok;

   assign Sl_errAck  = 1'b0;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;

   assign ctrl_word = {cnt_q, 13'b0, ovf_q, 1'b0, freeze_q};

   // An update is blocked only when freeze is set both before and after a
   // control write landing in the same cycle: setting freeze still lets this
   // cycle's word in, and clearing freeze admits it immediately.
   assign frozen_eff = freeze_q && !(ctrl_wr && !ctrl_wdata[FREEZE]);
   assign upd_accept = user_valid && !frozen_eff;

   always_comb begin
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      freeze_d = freeze_q;
      if (upd_accept) begin
         shadow_d = user_data_in;
         cnt_d    = cnt_q + 16'd1;
         if (cnt_q == 16'hFFFF) ovf_d = 1'b1;
      end else if (user_valid) begin
         ovf_d = 1'b1;
      end
      // Software writes land after the user-side events so clear wins.
      if (ctrl_wr) begin
         freeze_d = ctrl_wdata[FREEZE];
         if (ctrl_wdata[OVF]) ovf_d = 1'b0;
         if (ctrl_wdata[CLEAR]) begin
            cnt_d = '0;
            ovf_d = 1'b0;
         end
      end
   end

   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         shadow_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         freeze_q <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         freeze_q <= freeze_d;
      end
   end

`ifdef OPB_SIMULINK2PPC_TS_EN
   logic [31:0] ts_cnt_q;
   logic [31:0] ts_q;

   // Free-running cycle count, captured whenever a shadow update is taken.
   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         ts_cnt_q <= '0;
         ts_q     <= '0;
      end else begin
         ts_cnt_q <= ts_cnt_q + 32'd1;
         if (upd_accept) ts_q <= ts_cnt_q;
      end
   end

   assign ts_word = ts_q;
`else
   assign ts_word = '0;
`endif

   opb_s2p_bus_if #(
      .C_BASEADDR (C_BASEADDR),
      .C_HIGHADDR (C_HIGHADDR)
   ) u_bus_if (
      .clk_i        (OPB_Clk),
      .rst_i        (OPB_Rst),
      .abus_i       (OPB_ABus),
      .be_i         (OPB_BE),
      .dbus_i       (OPB_DBus),
      .rnw_i        (OPB_RNW),
      .select_i     (OPB_select),
      .data_word_i  (shadow_q),
      .ctrl_word_i  (ctrl_word),
      .ts_word_i    (ts_word),
      .sl_dbus_o    (Sl_DBus),
      .xfer_ack_o   (Sl_xferAck),
      .ctrl_wr_o    (ctrl_wr),
      .ctrl_wdata_o (ctrl_wdata),
      .state_o      (bus_state)
   );

   assign unused_ok = ^{OPB_seqAddr, ctrl_wdata[31:3], bus_state,
                        C_OPB_AWIDTH, C_OPB_DWIDTH, C_FAMILY};

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Directed bench for opb_register_simulink2ppc: OPB reads/writes, freeze,
// clear, overflow wrap, reset mid-transfer, out-of-window and timestamp.
module tb_opb_register_simulink2ppc;

  localparam logic [31:0] BASE = 32'h01008400;
  localparam logic [31:0] HIGH = 32'h010084FF;
  localparam logic [31:0] A_W0 = BASE + 32'h0;
  localparam logic [31:0] A_W1 = BASE + 32'h4;
  localparam logic [31:0] A_W2 = BASE + 32'h8;
  localparam logic [31:0] A_W3 = BASE + 32'hC;

  logic        clk;
  logic        rst;
  logic [0:31] sl_dbus;
  logic        sl_errack, sl_retry, sl_toutsup, sl_xferack;
  logic [0:31] opb_abus;
  logic [0:3]  opb_be;
  logic [0:31] opb_dbus;
  logic        opb_rnw, opb_select, opb_seqaddr;
  logic [31:0] user_data_in;
  logic        user_valid;

  int n_checks = 0;
  int n_errors = 0;
  int tb_cyc = 0;

  opb_register_simulink2ppc dut (
    .OPB_Clk      (clk),
    .OPB_Rst      (rst),
    .Sl_DBus      (sl_dbus),
    .Sl_errAck    (sl_errack),
    .Sl_retry     (sl_retry),
    .Sl_toutSup   (sl_toutsup),
    .Sl_xferAck   (sl_xferack),
    .OPB_ABus     (opb_abus),
    .OPB_BE       (opb_be),
    .OPB_DBus     (opb_dbus),
    .OPB_RNW      (opb_rnw),
    .OPB_select   (opb_select),
    .OPB_seqAddr  (opb_seqaddr),
    .user_data_in (user_data_in),
    .user_valid   (user_valid)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference cycle count since the last reset edge
  always @(posedge clk) begin
    if (rst) tb_cyc <= 0;
    else     tb_cyc <= tb_cyc + 1;
  end

  function automatic logic [31:0] from_bus(input logic [0:31] b);
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[31-i] = b[i];
    return v;
  endfunction

  function automatic logic [0:31] to_bus(input logic [31:0] v);
    logic [0:31] b;
    for (int i = 0; i < 32; i++) b[i] = v[31-i];
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks: drive on negedge, sample on negedge
  task automatic bus_xfer(input logic [31:0] addr, input logic rnw, input logic [31:0] wdata,
                          input logic [3:0] be, input bit uv_en, input logic [31:0] uv_data,
                          output logic [31:0] rdata, output bit acked, output int lat);
    @(negedge clk);
    opb_abus = to_bus(addr);
    opb_rnw = rnw;
    opb_dbus = rnw ? '0 : to_bus(wdata);
    opb_be = be;
    opb_select = 1'b1;
    acked = 0;
    rdata = '0;
    lat = 0;
    for (int i = 0; i < 8 && !acked; i++) begin
      @(negedge clk);
      if (sl_xferack) begin
        acked = 1;
        lat = i + 1;
        rdata = from_bus(sl_dbus);
        if (uv_en) begin
          user_valid = 1'b1;
          user_data_in = uv_data;
        end
      end
    end
    opb_select = 1'b0;
    opb_rnw = 1'b0;
    opb_abus = '0;
    opb_dbus = '0;
    @(negedge clk);
    user_valid = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bit a;
    int l;
    bus_xfer(addr, 1'b1, 32'h0, 4'hF, 0, 32'h0, d, a, l);
    check({tag, "_ack"}, 32'(a), 32'd1);
    check({tag, "_lat"}, 32'(l), 32'd1);
    check({tag, "_data"}, d, exp);
    check({tag, "_idle_dbus"}, from_bus(sl_dbus), 32'h0);
  endtask

  task automatic write_chk(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] be, input bit uv_en, input logic [31:0] uv_data);
    logic [31:0] d;
    bit a;
    int l;
    bus_xfer(addr, 1'b0, wd, be, uv_en, uv_data, d, a, l);
    check({tag, "_ack"}, 32'(a), 32'd1);
    check({tag, "_wr_dbus"}, d, 32'h0);
  endtask

  task automatic user_pulse(input logic [31:0] d);
    @(negedge clk);
    user_valid = 1'b1;
    user_data_in = d;
    @(negedge clk);
    user_valid = 1'b0;
  endtask

  task automatic miss_chk(input string tag, input logic [31:0] addr);
    logic [31:0] d;
    bit a;
    int l;
    bus_xfer(addr, 1'b1, 32'h0, 4'hF, 0, 32'h0, d, a, l);
    check({tag, "_noack"}, 32'(a), 32'd0);
    check({tag, "_dbus"}, from_bus(sl_dbus), 32'h0);
  endtask

  initial begin
    logic [31:0] exp_ts;
    int guard;
    rst = 1'b1;
    opb_abus = '0;
    opb_be = '0;
    opb_dbus = '0;
    opb_rnw = 1'b0;
    opb_select = 1'b0;
    opb_seqaddr = 1'b0;
    user_data_in = '0;
    user_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_xferack", 32'(sl_xferack), 32'd0);
    check("rst_dbus", from_bus(sl_dbus), 32'h0);
    check("rst_tied", {29'd0, sl_errack, sl_retry, sl_toutsup}, 32'h0);
    rst = 1'b0;

    read_chk("rd_w0_reset", A_W0, 32'h00000000);
    read_chk("rd_w1_reset", A_W1, 32'h00000000);

    user_pulse(32'hDEADBEEF);
    read_chk("rd_w0_upd", A_W0, 32'hDEADBEEF);
    read_chk("rd_w1_upd", A_W1, 32'h00010000);

    write_chk("wr_freeze", A_W1, 32'h1, 4'hF, 0, 32'h0);
    user_pulse(32'h12345678);
    read_chk("rd_w0_frozen", A_W0, 32'hDEADBEEF);
    read_chk("rd_w1_frozen", A_W1, 32'h00010005);

    write_chk("wr_unfreeze_clr", A_W1, 32'h2, 4'hF, 1, 32'hCAFEF00D);
    read_chk("rd_w1_clr", A_W1, 32'h00000000);
    read_chk("rd_w0_clr", A_W0, 32'hCAFEF00D);

    write_chk("wr_w0_ignored", A_W0, 32'hFFFFFFFF, 4'hF, 0, 32'h0);
    read_chk("rd_w0_after_w0wr", A_W0, 32'hCAFEF00D);

    write_chk("wr_freeze_uv", A_W1, 32'h1, 4'hF, 1, 32'h0BADF00D);
    read_chk("rd_w0_freeze_uv", A_W0, 32'h0BADF00D);
    read_chk("rd_w1_freeze_uv", A_W1, 32'h00010001);
    write_chk("wr_unfreeze2", A_W1, 32'h2, 4'hF, 0, 32'h0);
    write_chk("wr_be_gated", A_W1, 32'h1, 4'hE, 0, 32'h0);
    read_chk("rd_w1_be_gated", A_W1, 32'h00000000);

    @(negedge clk);
    for (int i = 0; i < 65536; i++) begin
      user_valid = 1'b1;
      user_data_in = 32'(i);
      @(negedge clk);
    end
    user_valid = 1'b0;
    read_chk("rd_w1_wrap", A_W1, 32'h00000004);
    read_chk("rd_w0_wrap", A_W0, 32'h0000FFFF);
    write_chk("wr_ovf_clr", A_W1, 32'h4, 4'hF, 0, 32'h0);
    read_chk("rd_w1_ovf_clr", A_W1, 32'h00000000);
    read_chk("rd_w3", A_W3, 32'h00000000);

    miss_chk("miss_high", HIGH + 32'h4);
    miss_chk("miss_low", BASE - 32'h4);

    user_pulse(32'h55AA55AA);
    write_chk("wr_freeze_pre_rst", A_W1, 32'h1, 4'hF, 0, 32'h0);
    @(negedge clk);
    opb_abus = to_bus(A_W0);
    opb_rnw = 1'b1;
    opb_be = 4'hF;
    opb_select = 1'b1;
    @(negedge clk);
    check("pre_rst_ack", 32'(sl_xferack), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_ack", 32'(sl_xferack), 32'd0);
    check("rst_mid_dbus", from_bus(sl_dbus), 32'h0);
    opb_select = 1'b0;
    opb_rnw = 1'b0;
    opb_abus = '0;
    @(negedge clk);
    check("rst_mid_ack2", 32'(sl_xferack), 32'd0);
    rst = 1'b0;
    read_chk("rd_w0_after_rst", A_W0, 32'h00000000);
    read_chk("rd_w1_after_rst", A_W1, 32'h00000000);

    guard = 0;
    while (tb_cyc < 100 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("ts_wait_cycle", 32'(tb_cyc), 32'd100);
`ifdef OPB_SIMULINK2PPC_TS_EN
    exp_ts = 32'(tb_cyc);
`else
    exp_ts = 32'h0;
`endif
    user_valid = 1'b1;
    user_data_in = 32'h13572468;
    @(negedge clk);
    user_valid = 1'b0;
    read_chk("rd_w0_ts_upd", A_W0, 32'h13572468);
    read_chk("rd_w2_ts", A_W2, exp_ts);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
